// File: rtl/valid_stream_pkg.sv
// Shared sizing helpers for the valid-only credit pipe (issuer and receiver sides).
package valid_stream_pkg;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Credit counter spans 0..depth inclusive, which fits in ptr_w for a power-of-2 depth.
  function automatic int unsigned credit_w(input int unsigned depth);
    return ptr_w(depth);
  endfunction

endpackage

// File: rtl/flip_flop_fifo_with_counter.sv
// Register-based circular buffer with wrap-bit pointers and an occupancy count.
module flip_flop_fifo_with_counter
  import valid_stream_pkg::*;
#(
  parameter int unsigned width      = 8,
  parameter int unsigned fifo_depth = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push,
  input  logic [width-1:0]                wdata,
  input  logic                            pop,
  output logic [width-1:0]                rdata,
  output logic                            empty,
  output logic                            full,
  output logic [ptr_w(fifo_depth)-1:0]    count
);

  localparam int unsigned PtrW  = ptr_w(fifo_depth);
  localparam int unsigned AddrW = addr_w(fifo_depth);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [width-1:0] mem_q [fifo_depth];
  logic             do_push, do_pop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
            (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);
    do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    do_push = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    count    = wr_ptr_q - rd_ptr_q;
    rdata    = mem_q[rd_ptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/valid_stream_credit_receiver.sv
// Credit-managed sink for a non-stallable valid-only pipe, re-presented as valid/ready.
// Define RECEIVER_BYPASS_EN for a zero-latency path when the buffer is empty.
module valid_stream_credit_receiver
  import valid_stream_pkg::*;
#(
  parameter int unsigned width      = 8,
  parameter int unsigned fifo_depth = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            issue,
  output logic                            can_issue,
  input  logic                            in_vld,
  input  logic [width-1:0]                in_data,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [width-1:0]                out_data,
  output logic [ptr_w(fifo_depth)-1:0]    count,
  output logic                            overflow
);

  localparam int unsigned CredW = credit_w(fifo_depth);
  localparam logic [CredW-1:0] CredMax = CredW'(fifo_depth);

  logic [CredW-1:0] reserved_q, reserved_d;
  logic             overflow_q, overflow_d;
  logic             pop;
  logic             fifo_push, fifo_pop;
  logic             fifo_empty, fifo_full;
  logic [width-1:0] fifo_rdata;

  flip_flop_fifo_with_counter #(
    .width      (width),
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

`ifdef RECEIVER_BYPASS_EN
  always_comb begin
    out_vld  = ~fifo_empty | in_vld;
    out_data = fifo_empty ? in_data : fifo_rdata;
    pop      = out_vld & out_rdy;
    // An arrival consumed straight through the bypass never touches the buffer.
    fifo_push = in_vld & ~(fifo_empty & out_rdy);
    fifo_pop  = pop & ~fifo_empty;
  end
`else
  always_comb begin
    out_vld   = ~fifo_empty;
    out_data  = fifo_rdata;
    pop       = out_vld & out_rdy;
    fifo_push = in_vld;
    fifo_pop  = pop;
  end
`endif

  always_comb begin
    reserved_d = reserved_q;
    overflow_d = overflow_q;
    if (issue && !pop) begin
      if (reserved_q == CredMax) begin
        overflow_d = 1'b1;
      end else begin
        reserved_d = reserved_q + 1'b1;
      end
    end else if (pop && !issue && (reserved_q != '0)) begin
      reserved_d = reserved_q - 1'b1;
    end
    if (in_vld && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reserved_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      reserved_q <= reserved_d;
      overflow_q <= overflow_d;
    end
  end

  assign can_issue = (reserved_q != CredMax);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_valid_stream_credit_receiver.sv
// Directed bench with an in-order scoreboard for valid_stream_credit_receiver.
module tb_valid_stream_credit_receiver;

  localparam int unsigned W = 8;
  localparam int unsigned D = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         issue;
  logic         can_issue;
  logic         in_vld;
  logic [W-1:0] in_data;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_data;
  logic [3:0]   count;
  logic         overflow;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb_q[$];

  valid_stream_credit_receiver #(
    .width      (W),
    .fifo_depth (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .can_issue (can_issue),
    .in_vld    (in_vld),
    .in_data   (in_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted output must match the oldest expected transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_vld === 1'b1 && out_rdy === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pop", {24'h0, out_data}, 32'hffff_ffff);
      end else begin
        chk("sb_data", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue n credits and deliver n transfers three cycles later, starting at base.
  task automatic fill(input int n, input logic [W-1:0] base);
    for (int c = 0; c < n + 3; c++) begin
      issue   = (c < n);
      in_vld  = (c >= 3);
      in_data = base + W'(c - 3);
      if (in_vld) sb_q.push_back(in_data);
      step();
    end
    issue  = 1'b0;
    in_vld = 1'b0;
  endtask

  task automatic drain();
    out_rdy = 1'b1;
    repeat (12) step();
    out_rdy = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    issue   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;
    #23 rst_n = 1'b1;

    // 1: reset and idle
    repeat (5) step();
    chk("rst_out_vld", {31'h0, out_vld}, 32'h0);
    chk("rst_can_issue", {31'h0, can_issue}, 32'h1);
    chk("rst_count", {28'h0, count}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);

    // 2: fill all credits, then drain in order
    for (int c = 0; c < 11; c++) begin
      issue   = (c < 8);
      in_vld  = (c >= 3);
      in_data = 8'h10 + W'(c - 3);
      if (in_vld) sb_q.push_back(in_data);
      if (c == 7) chk("can_issue_before_last", {31'h0, can_issue}, 32'h1);
      step();
    end
    issue  = 1'b0;
    in_vld = 1'b0;
    chk("full_can_issue", {31'h0, can_issue}, 32'h0);
    chk("full_count", {28'h0, count}, 32'h8);
    chk("full_out_vld", {31'h0, out_vld}, 32'h1);
    out_rdy = 1'b1;
    step();
    chk("credit_back", {31'h0, can_issue}, 32'h1);
    repeat (11) step();
    out_rdy = 1'b0;
    chk("drain_count", {28'h0, count}, 32'h0);
    chk("drain_sb_empty", sb_q.size(), 32'h0);

    // 3: push and pop together at full
    fill(8, 8'h20);
    chk("t3_full", {28'h0, count}, 32'h8);
    in_vld  = 1'b1;
    in_data = 8'h55;
    issue   = 1'b1;
    out_rdy = 1'b1;
    sb_q.push_back(8'h55);
    step();
    in_vld  = 1'b0;
    issue   = 1'b0;
    out_rdy = 1'b0;
    chk("t3_count", {28'h0, count}, 32'h8);
    chk("t3_overflow", {31'h0, overflow}, 32'h0);
    drain();
    chk("t3_sb_empty", sb_q.size(), 32'h0);

    // 4: protocol violations
    fill(8, 8'h30);
    issue = 1'b1;
    step();
    issue = 1'b0;
    chk("t4_overflow", {31'h0, overflow}, 32'h1);
    chk("t4_can_issue", {31'h0, can_issue}, 32'h0);
    in_vld  = 1'b1;
    in_data = 8'h99;
    step();
    in_vld = 1'b0;
    chk("t4_count", {28'h0, count}, 32'h8);
    chk("t4_head", {24'h0, out_data}, 32'h30);
    repeat (3) step();
    chk("t4_sticky", {31'h0, overflow}, 32'h1);
    drain();
    chk("t4_sb_empty", sb_q.size(), 32'h0);
    chk("t4_sticky_after", {31'h0, overflow}, 32'h1);

    // 5: asynchronous reset mid-stream
    fill(5, 8'h40);
    chk("t5_count", {28'h0, count}, 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_vld", {31'h0, out_vld}, 32'h0);
    chk("t5_count_rst", {28'h0, count}, 32'h0);
    chk("t5_can_issue", {31'h0, can_issue}, 32'h1);
    chk("t5_overflow", {31'h0, overflow}, 32'h0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 6: arrival into an empty buffer with downstream ready
    in_vld  = 1'b1;
    in_data = 8'hA5;
    out_rdy = 1'b1;
    sb_q.push_back(8'hA5);
    @(negedge clk);
`ifdef RECEIVER_BYPASS_EN
    chk("t6_bypass_vld", {31'h0, out_vld}, 32'h1);
    chk("t6_bypass_data", {24'h0, out_data}, 32'hA5);
`else
    chk("t6_no_bypass_vld", {31'h0, out_vld}, 32'h0);
`endif
    step();
    in_vld = 1'b0;
`ifdef RECEIVER_BYPASS_EN
    chk("t6_count", {28'h0, count}, 32'h0);
    chk("t6_out_vld_after", {31'h0, out_vld}, 32'h0);
`else
    chk("t6_count", {28'h0, count}, 32'h1);
    chk("t6_out_vld_after", {31'h0, out_vld}, 32'h1);
    chk("t6_data_after", {24'h0, out_data}, 32'hA5);
`endif
    step();
    out_rdy = 1'b0;
    chk("t6_count_final", {28'h0, count}, 32'h0);
    chk("t6_sb_empty", sb_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
